// File: rtl/cancid_dfa_ctx_mgr.sv
// Per-stream context manager for one DFA lane: restores the saved DFA state
// for a stream at packet start, streams characters to the DFA, drains the
// DFA pipeline and commits the final state plus a saturating match count.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for a packet start; sop_rdy=1
// LOAD    | registered read of the stream context and its valid bit
// RUN     | restored state presented on first cycle; accepting characters
// DRAIN   | DFA_LAT+1 cycles letting the last character's result register
// COMMIT  | write context/valid, update match_count, pulse commit_vld next
module cancid_dfa_ctx_mgr #(
    parameter int STATE_W    = 11,
    parameter int SID_W      = 6,
    parameter int COUNT_W    = 16,
    parameter int DFA_LAT    = 1,
    parameter int MATCH_MODE = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sop_vld,
    output logic               sop_rdy,
    input  logic [SID_W-1:0]   sop_sid,
    input  logic               sop_enable,
    input  logic               char_vld,
    output logic               char_rdy,
    input  logic [7:0]         char_data,
    input  logic               char_last,
    input  logic               ctx_clr,
    input  logic               cnt_clr,
    output logic [7:0]         dfa_char,
    output logic               dfa_char_vld,
    output logic [STATE_W-1:0] dfa_state_in,
    output logic               dfa_state_in_vld,
    input  logic [STATE_W-1:0] dfa_state_out,
    input  logic               dfa_accept,
    output logic [COUNT_W-1:0] match_count,
    output logic               commit_vld,
    output logic               pkt_fired
);

    localparam int NUM_STREAMS = 1 << SID_W;
    localparam int PIPE_D      = DFA_LAT + 1;
    // Mode 0 only needs a sticky flag; mode 1 counts every accept.
    localparam int HIT_W       = (MATCH_MODE != 0) ? COUNT_W : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DRAIN,
        ST_COMMIT
    } state_t;

    state_t               state_q, state_d;
    logic [SID_W-1:0]     sid_q, sid_d;
    logic                 en_q, en_d;
    logic [2:0]           drain_cnt_q, drain_cnt_d;
    logic [STATE_W-1:0]   state_in_q, state_in_d;
    logic                 state_in_vld_q, state_in_vld_d;
    logic [7:0]           dfa_char_q, dfa_char_d;
    logic                 dfa_char_vld_q, dfa_char_vld_d;
    logic [PIPE_D-1:0]    cvld_pipe_q, cvld_pipe_d;
    logic                 accept_r_q, accept_r_d;
    logic [STATE_W-1:0]   state_r_q, state_r_d;
    logic [HIT_W-1:0]     hit_cnt_q, hit_cnt_d;
    logic [COUNT_W-1:0]   match_count_q, match_count_d;
    logic                 commit_vld_q, commit_vld_d;
    logic                 pkt_fired_q, pkt_fired_d;
    logic [NUM_STREAMS-1:0] valid_q, valid_d;

    logic [STATE_W-1:0]   ctx_mem [NUM_STREAMS];
    logic                 ctx_we;
    logic                 commit_en;
    logic                 hit;
    logic [COUNT_W-1:0]   hits_ext;
    logic [COUNT_W:0]     sum;
    logic [COUNT_W-1:0]   sum_sat;

    // Control FSM: next state, stream latch, restore and character staging.
    always_comb begin
        state_d        = state_q;
        sid_d          = sid_q;
        en_d           = en_q;
        drain_cnt_d    = drain_cnt_q;
        state_in_d     = state_in_q;
        state_in_vld_d = 1'b0;
        dfa_char_d     = dfa_char_q;
        dfa_char_vld_d = 1'b0;
        commit_vld_d   = 1'b0;
        sop_rdy        = 1'b0;
        char_rdy       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                sop_rdy = 1'b1;
                if (sop_vld) begin
                    sid_d   = sop_sid;
                    en_d    = sop_enable;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_in_d     = valid_q[sid_q] ? ctx_mem[sid_q] : '0;
                state_in_vld_d = 1'b1;
                state_d        = ST_RUN;
            end
            ST_RUN: begin
                char_rdy = 1'b1;
                if (char_vld) begin
                    dfa_char_d     = char_data;
                    dfa_char_vld_d = 1'b1;
                    if (char_last) begin
                        drain_cnt_d = 3'(DFA_LAT);
                        state_d     = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_q == 3'd0) begin
                    state_d = ST_COMMIT;
                end else begin
                    drain_cnt_d = drain_cnt_q - 3'd1;
                end
            end
            ST_COMMIT: begin
                commit_vld_d = 1'b1;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // DFA result capture, hit accounting and commit-time count/valid update.
    always_comb begin
        accept_r_d  = dfa_accept;
        state_r_d   = dfa_state_out;
        cvld_pipe_d = {cvld_pipe_q[PIPE_D-2:0], dfa_char_vld_q};
        hit         = accept_r_q & cvld_pipe_q[PIPE_D-1];

        hit_cnt_d = hit_cnt_q;
        if (state_q == ST_RUN && state_in_vld_q) begin
            hit_cnt_d = '0;
        end else if (hit && hit_cnt_q != {HIT_W{1'b1}}) begin
            hit_cnt_d = hit_cnt_q + HIT_W'(1);
        end

        // The final character's hit lands in the COMMIT cycle itself, so the
        // commit uses the next-value of the hit counter.
        commit_en = (state_q == ST_COMMIT) && en_q;
        hits_ext  = COUNT_W'(hit_cnt_d);
        sum       = (COUNT_W+1)'(match_count_q) + (COUNT_W+1)'(hits_ext);
        sum_sat   = sum[COUNT_W] ? {COUNT_W{1'b1}} : sum[COUNT_W-1:0];

        match_count_d = match_count_q;
        if (commit_en) begin
            match_count_d = sum_sat;
        end
        if (cnt_clr) begin
            match_count_d = '0;
        end

        pkt_fired_d = commit_en && (hits_ext != '0);

        valid_d = valid_q;
        if (commit_en) begin
            valid_d[sid_q] = 1'b1;
        end
        if (ctx_clr) begin
            valid_d = '0;
        end

        ctx_we = commit_en && !rst;
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            sid_q          <= '0;
            en_q           <= 1'b0;
            drain_cnt_q    <= '0;
            state_in_q     <= '0;
            state_in_vld_q <= 1'b0;
            dfa_char_q     <= '0;
            dfa_char_vld_q <= 1'b0;
            cvld_pipe_q    <= '0;
            accept_r_q     <= 1'b0;
            state_r_q      <= '0;
            hit_cnt_q      <= '0;
            match_count_q  <= '0;
            commit_vld_q   <= 1'b0;
            pkt_fired_q    <= 1'b0;
            valid_q        <= '0;
        end else begin
            state_q        <= state_d;
            sid_q          <= sid_d;
            en_q           <= en_d;
            drain_cnt_q    <= drain_cnt_d;
            state_in_q     <= state_in_d;
            state_in_vld_q <= state_in_vld_d;
            dfa_char_q     <= dfa_char_d;
            dfa_char_vld_q <= dfa_char_vld_d;
            cvld_pipe_q    <= cvld_pipe_d;
            accept_r_q     <= accept_r_d;
            state_r_q      <= state_r_d;
            hit_cnt_q      <= hit_cnt_d;
            match_count_q  <= match_count_d;
            commit_vld_q   <= commit_vld_d;
            pkt_fired_q    <= pkt_fired_d;
            valid_q        <= valid_d;
        end
    end

    // Context RAM; contents are meaningful only where the valid bit is set.
    always_ff @(posedge clk) begin
        if (ctx_we) begin
            ctx_mem[sid_q] <= state_r_q;
        end
    end

    assign dfa_char         = dfa_char_q;
    assign dfa_char_vld     = dfa_char_vld_q;
    assign dfa_state_in     = state_in_q;
    assign dfa_state_in_vld = state_in_vld_q;
    assign match_count      = match_count_q;
    assign commit_vld       = commit_vld_q;
    assign pkt_fired        = pkt_fired_q;

endmodule

// File: tb/tb_cancid_dfa_ctx_mgr.sv
// Bench for cancid_dfa_ctx_mgr: two instances (mode 0 / latency 1 / 16-bit
// count and mode 1 / latency 2 / 4-bit count) each driven against a small
// behavioural DFA, with expected restores and commits queued at stimulus time.
module tb_cancid_dfa_ctx_mgr;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       sop_vld [2];
    logic       sop_rdy [2];
    logic [5:0] sop_sid [2];
    logic       sop_enable [2];
    logic       char_vld [2];
    logic       char_rdy [2];
    logic [7:0] char_data [2];
    logic       char_last [2];
    logic       ctx_clr [2];
    logic       cnt_clr [2];
    logic [7:0] dfa_char [2];
    logic       dfa_char_vld [2];
    logic [10:0] dfa_state_in [2];
    logic       dfa_state_in_vld [2];
    logic [10:0] dfa_state_out [2];
    logic       dfa_accept [2];
    logic       commit_vld [2];
    logic       pkt_fired [2];
    logic [15:0] match_count0;
    logic [3:0]  match_count1;

    int n_checks = 0;
    int n_errors = 0;
    localparam int LAT [2]  = '{1, 2};
    localparam int MODE [2] = '{0, 1};
    localparam int CMAX [2] = '{65535, 15};

    cancid_dfa_ctx_mgr #(.STATE_W(11), .SID_W(6), .COUNT_W(16), .DFA_LAT(1), .MATCH_MODE(0)) u_dut0 (
        .clk(clk), .rst(rst), .sop_vld(sop_vld[0]), .sop_rdy(sop_rdy[0]), .sop_sid(sop_sid[0]),
        .sop_enable(sop_enable[0]), .char_vld(char_vld[0]), .char_rdy(char_rdy[0]),
        .char_data(char_data[0]), .char_last(char_last[0]), .ctx_clr(ctx_clr[0]), .cnt_clr(cnt_clr[0]),
        .dfa_char(dfa_char[0]), .dfa_char_vld(dfa_char_vld[0]), .dfa_state_in(dfa_state_in[0]),
        .dfa_state_in_vld(dfa_state_in_vld[0]), .dfa_state_out(dfa_state_out[0]),
        .dfa_accept(dfa_accept[0]), .match_count(match_count0), .commit_vld(commit_vld[0]),
        .pkt_fired(pkt_fired[0]));

    cancid_dfa_ctx_mgr #(.STATE_W(11), .SID_W(6), .COUNT_W(4), .DFA_LAT(2), .MATCH_MODE(1)) u_dut1 (
        .clk(clk), .rst(rst), .sop_vld(sop_vld[1]), .sop_rdy(sop_rdy[1]), .sop_sid(sop_sid[1]),
        .sop_enable(sop_enable[1]), .char_vld(char_vld[1]), .char_rdy(char_rdy[1]),
        .char_data(char_data[1]), .char_last(char_last[1]), .ctx_clr(ctx_clr[1]), .cnt_clr(cnt_clr[1]),
        .dfa_char(dfa_char[1]), .dfa_char_vld(dfa_char_vld[1]), .dfa_state_in(dfa_state_in[1]),
        .dfa_state_in_vld(dfa_state_in_vld[1]), .dfa_state_out(dfa_state_out[1]),
        .dfa_accept(dfa_accept[1]), .match_count(match_count1), .commit_vld(commit_vld[1]),
        .pkt_fired(pkt_fired[1]));

    function automatic logic [10:0] dfa_nxt(input logic [10:0] s, input logic [7:0] c);
        return s * 11'd3 + {3'b000, c};
    endfunction

    function automatic logic dfa_acc(input logic [7:0] c);
        return (c == 8'h62) || (c == 8'h78);
    endfunction

    // Behavioural DFA with DFA_LAT cycles from char to state/accept.
    logic [10:0] m_cur [2];
    logic [10:0] m_st [2][4];
    logic        m_acc [2][4];
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_cur[d] <= '0;
                for (int k = 0; k < 4; k++) begin
                    m_st[d][k]  <= '0;
                    m_acc[d][k] <= 1'b0;
                end
            end else begin
                if (dfa_state_in_vld[d]) begin
                    m_cur[d]   <= dfa_state_in[d];
                    m_acc[d][0] <= 1'b0;
                end else if (dfa_char_vld[d]) begin
                    m_cur[d]    <= dfa_nxt(m_cur[d], dfa_char[d]);
                    m_st[d][0]  <= dfa_nxt(m_cur[d], dfa_char[d]);
                    m_acc[d][0] <= dfa_acc(dfa_char[d]);
                end else begin
                    m_acc[d][0] <= 1'b0;
                end
                for (int k = 1; k < 4; k++) begin
                    m_st[d][k]  <= m_st[d][k-1];
                    m_acc[d][k] <= m_acc[d][k-1];
                end
            end
        end
    end
    assign dfa_state_out[0] = m_st[0][0];
    assign dfa_accept[0]    = m_acc[0][0];
    assign dfa_state_out[1] = m_st[1][1];
    assign dfa_accept[1]    = m_acc[1][1];

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard state.
    typedef struct { int fired; int cnt; } commit_t;
    int      sq0 [$];
    int      sq1 [$];
    commit_t cq0 [$];
    commit_t cq1 [$];
    int      exp_ctx [2][64];
    bit      exp_valid [2][64];
    int      exp_cnt [2];

    function automatic int get_mc(input int d);
        return (d == 0) ? int'(match_count0) : int'(match_count1);
    endfunction

    // Monitor: compare restores and commits against queued expectations.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst && dfa_state_in_vld[d]) begin
                if ((d == 0 ? sq0.size() : sq1.size()) == 0) check("unexpected_restore", 1, 0);
                else if (d == 0) check("state_in_d0", int'(dfa_state_in[0]), sq0.pop_front());
                else check("state_in_d1", int'(dfa_state_in[1]), sq1.pop_front());
            end
            if (!rst && commit_vld[d]) begin
                commit_t e;
                if ((d == 0 ? cq0.size() : cq1.size()) == 0) begin
                    check("unexpected_commit", 1, 0);
                end else begin
                    e = (d == 0) ? cq0.pop_front() : cq1.pop_front();
                    check(d == 0 ? "fired_d0" : "fired_d1", int'(pkt_fired[d]), e.fired);
                    check(d == 0 ? "count_d0" : "count_d1", get_mc(d), e.cnt);
                end
            end
        end
    end

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            exp_cnt[d] = 0;
            for (int s = 0; s < 64; s++) exp_valid[d][s] = 1'b0;
        end
    endtask

    // mode: 0 plain, 1 ctx_clr at COMMIT, 2 cnt_clr at COMMIT, 3 reset mid-packet
    task automatic send_pkt(input int d, input int sid, input int en, input string s, input int mode);
        logic [10:0] st;
        int acc;
        int n;
        commit_t e;
        st = exp_valid[d][sid] ? exp_ctx[d][sid][10:0] : 11'd0;
        if (d == 0) sq0.push_back(int'(st)); else sq1.push_back(int'(st));
        acc = 0;
        for (int i = 0; i < s.len(); i++) begin
            st = dfa_nxt(st, s[i]);
            if (dfa_acc(s[i])) acc++;
        end
        if (mode != 3) begin
            e.fired = (en != 0 && acc > 0) ? 1 : 0;
            if (en != 0) begin
                exp_cnt[d] += (MODE[d] != 0) ? acc : (acc > 0 ? 1 : 0);
                if (exp_cnt[d] > CMAX[d]) exp_cnt[d] = CMAX[d];
                exp_ctx[d][sid]   = int'(st);
                exp_valid[d][sid] = 1'b1;
            end
            if (mode == 2) exp_cnt[d] = 0;
            if (mode == 1) for (int k = 0; k < 64; k++) exp_valid[d][k] = 1'b0;
            e.cnt = exp_cnt[d];
            if (d == 0) cq0.push_back(e); else cq1.push_back(e);
        end

        n = 0;
        while (!sop_rdy[d] && n < 20) begin @(posedge clk); #1; n++; end
        if (n >= 20) check("sop_rdy_timeout", n, 0);
        sop_vld[d] = 1'b1; sop_sid[d] = 6'(sid); sop_enable[d] = (en != 0);
        @(posedge clk); #1;
        sop_vld[d] = 1'b0;
        n = 1;
        while (!char_rdy[d] && n < 20) begin @(posedge clk); #1; n++; end
        check("sop_to_char_rdy", n, 2);
        for (int i = 0; i < s.len(); i++) begin
            char_vld[d] = 1'b1; char_data[d] = s[i];
            char_last[d] = (i == s.len() - 1) && (mode != 3);
            @(posedge clk); #1;
        end
        char_vld[d] = 1'b0; char_last[d] = 1'b0;
        if (mode == 3) begin
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            model_reset();
            return;
        end
        n = 1;
        while (!commit_vld[d] && n < 20) begin
            if (n == LAT[d] + 2) begin
                ctx_clr[d] = (mode == 1);
                cnt_clr[d] = (mode == 2);
            end
            @(posedge clk); #1;
            ctx_clr[d] = 1'b0; cnt_clr[d] = 1'b0;
            n++;
        end
        check("last_to_commit", n, LAT[d] + 3);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            sop_vld[d] = 0; sop_sid[d] = '0; sop_enable[d] = 0; char_vld[d] = 0;
            char_data[d] = '0; char_last[d] = 0; ctx_clr[d] = 0; cnt_clr[d] = 0;
        end
        model_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            check("rst_sop_rdy", int'(sop_rdy[d]), 1);
            check("rst_char_rdy", int'(char_rdy[d]), 0);
            check("rst_commit_vld", int'(commit_vld[d]), 0);
            check("rst_pkt_fired", int'(pkt_fired[d]), 0);
            check("rst_dfa_char_vld", int'(dfa_char_vld[d]), 0);
            check("rst_state_in", int'(dfa_state_in[d]), 0);
            check("rst_match_count", get_mc(d), 0);
        end

        // char_vld outside RUN is ignored.
        for (int i = 0; i < 3; i++) begin
            char_vld[0] = 1'b1; char_data[0] = 8'h62;
            @(posedge clk); #1;
            check("idle_char_ignored", int'(dfa_char_vld[0]), 0);
        end
        char_vld[0] = 1'b0;

        // Mode 0, latency 1.
        send_pkt(0, 5, 1, "ab", 0);
        send_pkt(0, 5, 1, "bcb", 0);
        send_pkt(0, 6, 1, "cd", 0);
        send_pkt(0, 5, 0, "xb", 0);
        send_pkt(0, 5, 1, "c", 0);
        send_pkt(0, 7, 1, "ax", 1);
        send_pkt(0, 7, 1, "b", 0);
        send_pkt(0, 5, 1, "ab", 0);
        send_pkt(0, 5, 1, "b", 2);
        send_pkt(0, 8, 1, "xa", 0);
        send_pkt(0, 8, 1, "xbx", 3);
        repeat (8) @(posedge clk);
        #1 check("mc_after_rst", get_mc(0), 0);
        send_pkt(0, 8, 1, "q", 0);

        // Mode 1, latency 2, 4-bit saturating count.
        send_pkt(1, 3, 1, "xxx", 0);
        send_pkt(1, 3, 1, "axbxcx", 0);
        send_pkt(1, 4, 1, "xxxxxxxx", 0);
        send_pkt(1, 3, 1, "xbx", 0);
        send_pkt(1, 4, 1, "bb", 0);
        send_pkt(1, 4, 0, "b", 0);

        repeat (10) @(posedge clk);
        #1;
        check("restore_queue_empty", sq0.size() + sq1.size(), 0);
        check("commit_queue_empty", cq0.size() + cq1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
